perip_arbiter: RTL and testbench
================================

Name: perip_arbiter

Overview:
- Two-master arbiter sharing the single peripheral data port (perip_addr/wen/mask/wdata/rdata) between the CPU load/store stage (master 0) and a secondary bus master such as a debug/DMA engine (master 1).
- Sits between the CPU core and the peripheral/RAM fabric.
- Arbitrates per transfer with fixed or round-robin priority. Adds a starvation guard and a bounded lock for master 1, and routes read data back to the issuing master.

Parameters:
- CPU_PRIO, 1, 1 = master 0 wins contention (subject to starvation guard); 0 = round-robin.
- STARVE_MAX, 8, contended cycles master 1 may wait before a forced grant (1..255).
- LOCK_MAX, 4, maximum consecutive locked grants to master 1 while master 0 waits (1..255).

Ports:
- cpu_clk  in  1  clock
- cpu_rst  in  1  reset; asynchronous, active-low
- m0_req  in  1  master 0 transfer request
- m0_addr  in  32  master 0 address
- m0_wen  in  1  master 0 write enable (0 = read)
- m0_mask  in  2  master 0 size mask (passed through unchanged)
- m0_wdata  in  32  master 0 write data
- m0_gnt  out  1  transfer accepted this cycle
- m0_rvalid  out  1  read data valid for master 0
- m0_rdata  out  32  read data for master 0
- m1_req, m1_addr, m1_wen, m1_mask, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same widths and meanings for master 1
- m1_lock  in  1  master 1 requests back-to-back ownership
- perip_addr  out  32  shared bus address
- perip_wen  out  1  shared bus write enable
- perip_mask  out  2  shared bus mask
- perip_wdata  out  32  shared bus write data
- perip_rdata  in  32  slave read data, valid one cycle after a read address
- owner  out  2  00 = idle, 01 = master 0, 10 = master 1 (combinational, mirrors grant this cycle)

Behaviour:
- Protocol:
  - A transfer is one cycle with mX_req=1 and mX_gnt=1.
  - A master holds req/addr/wen/mask/wdata stable until gnt. Dropping req before gnt is a protocol violation; no checking is done.
  - At most one gnt per cycle. gnt is combinational from req plus registered state, giving zero-wait acceptance when uncontended.
- Bus drive:
  - The granted master's addr/wen/mask/wdata drive perip_* in the same cycle.
  - With no grant: perip_wen=0 and addr/mask/wdata=0, so writes can never leak.
- Grant decision, in priority order:
  - (1) Lock: last grant was master 1, m1_lock=1, m1_req=1 and lock_cnt<LOCK_MAX → master 1.
  - (2) Starvation: starve_cnt==STARVE_MAX and m1_req → master 1.
  - (3) Single requester → that requester.
  - (4) Both requesting, CPU_PRIO=1 → master 0; CPU_PRIO=0 → the master not granted last (last_gnt).
- Registered state:
  - last_gnt: updated on every grant. Reset value = master 1, so master 0 wins the first round-robin contest.
  - starve_cnt (8 bit): +1 when m1_req && m0_gnt, saturating at STARVE_MAX. Cleared on m1_gnt or when m1_req=0.
  - lock_cnt (8 bit): +1 on each m1_gnt while m1_lock && m0_req. Cleared on m0_gnt, on m1_lock=0, or when no grant occurs.
  - When lock_cnt reaches LOCK_MAX with m0_req=1, master 0 takes the next grant: the lock is suspended for that cycle, and master 1 then re-contends normally.
- Read return:
  - Registered rd_pend[1:0] = {m1 read granted, m0 read granted}, captured on a gnt with wen=0.
  - Next cycle: mX_rvalid = rd_pend[X] and mX_rdata = perip_rdata. The inactive master's rdata is 0.
  - Writes produce no rvalid.
  - Back-to-back reads are fully pipelined, with one return per cycle.
- Reset (cpu_rst=0, asynchronous):
  - All gnt/rvalid/owner=0, perip_* = 0, counters 0, rd_pend=0, last_gnt = master 1.
  - A read in flight at reset is dropped; no rvalid after release.
- Simultaneous starvation and lock: starvation only counts while master 1 is not granted, so the two cannot conflict.

Test Plan:
- Uncontended: m0 read addr 0x8000_0010 with slave rdata 0x1234_5678 → m0_gnt same cycle, owner=01, m0_rvalid=1 next cycle with m0_rdata=0x1234_5678, m1_rvalid=0.
- Contention with CPU_PRIO=1, STARVE_MAX=8, both req continuously → m0 granted cycles 0-7, m1 granted cycle 8, starve_cnt returns to 0, m0 resumes.
- Round-robin with CPU_PRIO=0, both req 6 cycles → grants alternate m0, m1, m0, m1, m0, m1 from reset.
- Lock with LOCK_MAX=4: m1_lock=1 with m0 and m1 both requesting after an initial m1 grant → 4 further locked m1 grants, then one m0 grant, then m1 re-contends normally; perip_wen never asserted for the non-granted master.
- Idle bus: no req for 3 cycles with m0 holding wdata=0xDEAD_BEEF and wen=1 but req=0 → perip_wen=0, perip_addr=0, owner=00, no gnt.
- Reset mid-read: m1 read granted, cpu_rst low the following cycle → m1_rvalid=0, counters 0, and the first post-reset contention goes to m0.

Source files
------------

// File: rtl/perip_arbiter.sv
// Two-master arbiter for the shared peripheral data port.
// Ports: cpu_clk, cpu_rst (async, active-low)
//        m0_*: CPU load/store master (req/addr/wen/mask/wdata in, gnt/rvalid/rdata out)
//        m1_*: secondary master, same as m0_* plus m1_lock (back-to-back ownership)
//        perip_*: shared bus (addr/wen/mask/wdata out, rdata in one cycle after a read)
//        owner: {m1_gnt, m0_gnt} for the current cycle
module perip_arbiter #(
    parameter int unsigned CPU_PRIO   = 1,
    parameter int unsigned STARVE_MAX = 8,
    parameter int unsigned LOCK_MAX   = 4
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,

    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic        m0_wen,
    input  logic [1:0]  m0_mask,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic        m1_wen,
    input  logic [1:0]  m1_mask,
    input  logic [31:0] m1_wdata,
    input  logic        m1_lock,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,

    output logic [31:0] perip_addr,
    output logic        perip_wen,
    output logic [1:0]  perip_mask,
    output logic [31:0] perip_wdata,
    input  logic [31:0] perip_rdata,

    output logic [1:0]  owner
);

    localparam logic [7:0] SMAX = 8'(STARVE_MAX);
    localparam logic [7:0] LMAX = 8'(LOCK_MAX);

    // last_gnt: 1 = master 1 was granted last
    logic       last_gnt_q, last_gnt_d;
    logic [7:0] starve_cnt_q, starve_cnt_d;
    logic [7:0] lock_cnt_q, lock_cnt_d;
    logic [1:0] rd_pend_q, rd_pend_d;

    logic lock_act;
    logic starve_act;
    logic any_gnt;

    // Grant decision; reset gates grants so nothing reaches the bus
    always_comb begin
        m0_gnt     = 1'b0;
        m1_gnt     = 1'b0;
        lock_act   = last_gnt_q && m1_lock && m1_req && (lock_cnt_q < LMAX);
        starve_act = (starve_cnt_q == SMAX) && m1_req;
        if (!cpu_rst) begin
            m0_gnt = 1'b0;
            m1_gnt = 1'b0;
        end else if (lock_act || starve_act) begin
            m1_gnt = 1'b1;
        end else if (m0_req && !m1_req) begin
            m0_gnt = 1'b1;
        end else if (m1_req && !m0_req) begin
            m1_gnt = 1'b1;
        end else if (m0_req && m1_req) begin
            if (CPU_PRIO != 0) begin
                m0_gnt = 1'b1;
            end else if (last_gnt_q) begin
                m0_gnt = 1'b1;
            end else begin
                m1_gnt = 1'b1;
            end
        end
    end

    assign any_gnt = m0_gnt || m1_gnt;
    assign owner   = {m1_gnt, m0_gnt};

    // Bus mux; an idle bus is all zero so a stray wen cannot leak
    always_comb begin
        perip_addr  = '0;
        perip_wen   = 1'b0;
        perip_mask  = '0;
        perip_wdata = '0;
        if (m0_gnt) begin
            perip_addr  = m0_addr;
            perip_wen   = m0_wen;
            perip_mask  = m0_mask;
            perip_wdata = m0_wdata;
        end else if (m1_gnt) begin
            perip_addr  = m1_addr;
            perip_wen   = m1_wen;
            perip_mask  = m1_mask;
            perip_wdata = m1_wdata;
        end
    end

    // Next-state for arbitration history and read tracking
    always_comb begin
        last_gnt_d   = last_gnt_q;
        starve_cnt_d = starve_cnt_q;
        lock_cnt_d   = lock_cnt_q;
        rd_pend_d    = {m1_gnt && !m1_wen, m0_gnt && !m0_wen};

        if (any_gnt) begin
            last_gnt_d = m1_gnt;
        end

        if (m1_gnt || !m1_req) begin
            starve_cnt_d = '0;
        end else if (m0_gnt && (starve_cnt_q < SMAX)) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end

        if (m0_gnt || !m1_lock || !any_gnt) begin
            lock_cnt_d = '0;
        end else if (m1_gnt && m0_req && (lock_cnt_q < LMAX)) begin
            lock_cnt_d = lock_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            last_gnt_q   <= 1'b1;
            starve_cnt_q <= '0;
            lock_cnt_q   <= '0;
            rd_pend_q    <= '0;
        end else begin
            last_gnt_q   <= last_gnt_d;
            starve_cnt_q <= starve_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
            rd_pend_q    <= rd_pend_d;
        end
    end

    // Read data is steered only to the master whose read is in flight
    assign m0_rvalid = rd_pend_q[0];
    assign m1_rvalid = rd_pend_q[1];
    assign m0_rdata  = rd_pend_q[0] ? perip_rdata : '0;
    assign m1_rdata  = rd_pend_q[1] ? perip_rdata : '0;

endmodule

// File: tb/tb_perip_arbiter.sv
// Directed bench for perip_arbiter.
// Fixed-priority instance u_dut plus round-robin instance u_rr on shared stimulus.
module tb_perip_arbiter;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b0;
    logic        m0_req = 1'b0, m0_wen = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic [1:0]  m0_mask = '0;
    logic        m1_req = 1'b0, m1_wen = 1'b0, m1_lock = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic [1:0]  m1_mask = '0;
    logic [31:0] perip_rdata = '0;

    logic        d_m0_gnt, d_m0_rvalid, d_m1_gnt, d_m1_rvalid, d_pwen;
    logic [31:0] d_m0_rdata, d_m1_rdata, d_paddr, d_pwdata;
    logic [1:0]  d_pmask, d_owner;

    logic        r_m0_gnt, r_m0_rvalid, r_m1_gnt, r_m1_rvalid, r_pwen;
    logic [31:0] r_m0_rdata, r_m1_rdata, r_paddr, r_pwdata;
    logic [1:0]  r_pmask, r_owner;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 cpu_clk = ~cpu_clk;

    perip_arbiter #(.CPU_PRIO(1), .STARVE_MAX(8), .LOCK_MAX(4)) u_dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wen(m0_wen),
        .m0_mask(m0_mask), .m0_wdata(m0_wdata),
        .m0_gnt(d_m0_gnt), .m0_rvalid(d_m0_rvalid), .m0_rdata(d_m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wen(m1_wen),
        .m1_mask(m1_mask), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
        .m1_gnt(d_m1_gnt), .m1_rvalid(d_m1_rvalid), .m1_rdata(d_m1_rdata),
        .perip_addr(d_paddr), .perip_wen(d_pwen), .perip_mask(d_pmask),
        .perip_wdata(d_pwdata), .perip_rdata(perip_rdata),
        .owner(d_owner)
    );

    perip_arbiter #(.CPU_PRIO(0), .STARVE_MAX(8), .LOCK_MAX(4)) u_rr (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wen(m0_wen),
        .m0_mask(m0_mask), .m0_wdata(m0_wdata),
        .m0_gnt(r_m0_gnt), .m0_rvalid(r_m0_rvalid), .m0_rdata(r_m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wen(m1_wen),
        .m1_mask(m1_mask), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
        .m1_gnt(r_m1_gnt), .m1_rvalid(r_m1_rvalid), .m1_rdata(r_m1_rdata),
        .perip_addr(r_paddr), .perip_wen(r_pwen), .perip_mask(r_pmask),
        .perip_wdata(r_pwdata), .perip_rdata(perip_rdata),
        .owner(r_owner)
    );

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_wen = 0; m0_addr = '0; m0_wdata = '0; m0_mask = '0;
        m1_req = 0; m1_wen = 0; m1_addr = '0; m1_wdata = '0; m1_mask = '0;
        m1_lock = 0; perip_rdata = '0;
    endtask

    task automatic test_reset();
        cpu_rst = 0;
        m0_req = 1; m0_wen = 1; m0_addr = 32'h4; m0_wdata = 32'h55;
        @(negedge cpu_clk);
        n_checks++;
        if ({d_m0_gnt, d_m1_gnt, d_owner} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_gnt got %b want 0000",
                     {d_m0_gnt, d_m1_gnt, d_owner});
        end
        n_checks++;
        if ({d_pwen, d_paddr, d_pwdata, d_pmask} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_bus got wen=%b addr=%h wdata=%h want 0",
                     d_pwen, d_paddr, d_pwdata);
        end
        n_checks++;
        if ({d_m0_rvalid, d_m1_rvalid, r_m0_gnt, r_m1_gnt} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_rv got %b want 0000",
                     {d_m0_rvalid, d_m1_rvalid, r_m0_gnt, r_m1_gnt});
        end
        n_checks++;
        if ({u_dut.last_gnt_q, u_dut.starve_cnt_q, u_dut.lock_cnt_q} !== 17'h10000) begin
            n_fail++;
            $display("FAIL reset_state got last=%b st=%0d lk=%0d want 1,0,0",
                     u_dut.last_gnt_q, u_dut.starve_cnt_q, u_dut.lock_cnt_q);
        end
        tick();
        cpu_rst = 1;
        idle_inputs();
    endtask

    task automatic test_uncontended();
        m0_req = 1; m0_wen = 0; m0_addr = 32'h8000_0010; m0_mask = 2'b10;
        @(negedge cpu_clk);
        n_checks++;
        if ({d_m0_gnt, d_m1_gnt, d_owner} !== 4'b1001) begin
            n_fail++;
            $display("FAIL unc_gnt got %b want 1001", {d_m0_gnt, d_m1_gnt, d_owner});
        end
        n_checks++;
        if ({d_paddr, d_pwen, d_pmask} !== {32'h8000_0010, 1'b0, 2'b10}) begin
            n_fail++;
            $display("FAIL unc_bus got addr=%h wen=%b mask=%b want 80000010,0,10",
                     d_paddr, d_pwen, d_pmask);
        end
        tick();
        m0_req = 0;
        perip_rdata = 32'h1234_5678;
        @(negedge cpu_clk);
        n_checks++;
        if ({d_m0_rvalid, d_m0_rdata} !== {1'b1, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL unc_rdata got rv=%b data=%h want 1,12345678",
                     d_m0_rvalid, d_m0_rdata);
        end
        n_checks++;
        if ({d_m1_rvalid, d_m1_rdata} !== 33'd0) begin
            n_fail++;
            $display("FAIL unc_m1_quiet got rv=%b data=%h want 0,0",
                     d_m1_rvalid, d_m1_rdata);
        end
        tick();
        perip_rdata = '0;
        @(negedge cpu_clk);
        n_checks++;
        if ({d_m0_rvalid, r_m0_rvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL unc_single_rv got %b want 00", {d_m0_rvalid, r_m0_rvalid});
        end
        tick();
    endtask

    task automatic test_idle();
        m0_req = 0; m0_wen = 1; m0_wdata = 32'hDEAD_BEEF; m0_addr = 32'h40;
        for (int c = 0; c < 3; c++) begin
            @(negedge cpu_clk);
            n_checks++;
            if ({d_pwen, d_paddr, d_pwdata, d_owner, d_m0_gnt, d_m1_gnt} !== 69'd0) begin
                n_fail++;
                $display("FAIL idle_c%0d got wen=%b addr=%h wdata=%h owner=%b",
                         c, d_pwen, d_paddr, d_pwdata, d_owner);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_starvation();
        logic [1:0] exp;
        m0_req = 1; m0_wen = 1; m0_wdata = 32'hA0A0_0000; m0_addr = 32'h100;
        m1_req = 1; m1_wen = 1; m1_wdata = 32'hB1B1_0000; m1_addr = 32'h200;
        for (int c = 0; c < 10; c++) begin
            exp = (c == 8) ? 2'b01 : 2'b10;
            @(negedge cpu_clk);
            n_checks++;
            if ({d_m0_gnt, d_m1_gnt} !== exp) begin
                n_fail++;
                $display("FAIL starve_c%0d got %b want %b", c, {d_m0_gnt, d_m1_gnt}, exp);
            end
            n_checks++;
            if (d_pwdata !== ((c == 8) ? 32'hB1B1_0000 : 32'hA0A0_0000)) begin
                n_fail++;
                $display("FAIL starve_wd_c%0d got %h", c, d_pwdata);
            end
            if (c == 9) begin
                n_checks++;
                if (u_dut.starve_cnt_q !== 8'd0) begin
                    n_fail++;
                    $display("FAIL starve_clr got %0d want 0", u_dut.starve_cnt_q);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_round_robin();
        cpu_rst = 0;
        tick();
        cpu_rst = 1;
        m0_req = 1; m0_wen = 1; m0_addr = 32'h10;
        m1_req = 1; m1_wen = 1; m1_addr = 32'h20;
        for (int c = 0; c < 6; c++) begin
            @(negedge cpu_clk);
            n_checks++;
            if ({r_m0_gnt, r_m1_gnt} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL rr_c%0d got %b want %b", c, {r_m0_gnt, r_m1_gnt},
                         (c % 2 == 0) ? 2'b10 : 2'b01);
            end
            n_checks++;
            if ({d_m0_gnt, d_m1_gnt} !== 2'b10) begin
                n_fail++;
                $display("FAIL prio_c%0d got %b want 10", c, {d_m0_gnt, d_m1_gnt});
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_lock();
        m1_req = 1; m1_lock = 1; m1_wen = 0; m1_addr = 32'h300;
        m1_wdata = 32'h1111_1111;
        @(negedge cpu_clk);
        n_checks++;
        if ({d_m0_gnt, d_m1_gnt} !== 2'b01) begin
            n_fail++;
            $display("FAIL lock_first got %b want 01", {d_m0_gnt, d_m1_gnt});
        end
        tick();
        m0_req = 1; m0_wen = 1; m0_addr = 32'h400; m0_wdata = 32'h2222_2222;
        for (int c = 1; c <= 6; c++) begin
            @(negedge cpu_clk);
            n_checks++;
            if ({d_m0_gnt, d_m1_gnt} !== ((c <= 4) ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL lock_c%0d got %b want %b", c, {d_m0_gnt, d_m1_gnt},
                         (c <= 4) ? 2'b01 : 2'b10);
            end
            n_checks++;
            if ({d_pwen, d_paddr} !== ((c <= 4) ? {1'b0, 32'h300} : {1'b1, 32'h400})) begin
                n_fail++;
                $display("FAIL lock_bus_c%0d got wen=%b addr=%h", c, d_pwen, d_paddr);
            end
            if (c == 6) begin
                n_checks++;
                if (u_dut.lock_cnt_q !== 8'd0) begin
                    n_fail++;
                    $display("FAIL lock_clr got %0d want 0", u_dut.lock_cnt_q);
                end
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_read();
        m1_req = 1; m1_wen = 0; m1_addr = 32'h500;
        @(negedge cpu_clk);
        n_checks++;
        if (d_m1_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL rmr_gnt got %b want 1", d_m1_gnt);
        end
        tick();
        cpu_rst = 0;
        m1_req = 0;
        perip_rdata = 32'hCAFE_0001;
        @(negedge cpu_clk);
        n_checks++;
        if ({d_m1_rvalid, r_m1_rvalid, d_m1_rdata} !== 34'd0) begin
            n_fail++;
            $display("FAIL rmr_rv got rv=%b/%b data=%h want 0",
                     d_m1_rvalid, r_m1_rvalid, d_m1_rdata);
        end
        n_checks++;
        if ({u_dut.starve_cnt_q, u_dut.lock_cnt_q} !== 16'd0) begin
            n_fail++;
            $display("FAIL rmr_cnt got st=%0d lk=%0d want 0",
                     u_dut.starve_cnt_q, u_dut.lock_cnt_q);
        end
        tick();
        cpu_rst = 1;
        @(negedge cpu_clk);
        n_checks++;
        if ({d_m1_rvalid, r_m1_rvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL rmr_post_rv got %b want 00", {d_m1_rvalid, r_m1_rvalid});
        end
        tick();
        m0_req = 1; m0_wen = 1; m1_req = 1; m1_wen = 1;
        @(negedge cpu_clk);
        n_checks++;
        if ({r_m0_gnt, r_m1_gnt, d_m0_gnt, d_m1_gnt} !== 4'b1010) begin
            n_fail++;
            $display("FAIL rmr_first got rr=%b prio=%b want 10,10",
                     {r_m0_gnt, r_m1_gnt}, {d_m0_gnt, d_m1_gnt});
        end
        tick();
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_uncontended();
        test_idle();
        test_starvation();
        test_round_robin();
        test_lock();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
